// File: rtl/noc_pkg.sv
// noc_pkg: shared packet-state enum and counter-width helper for the NoC link stage
package noc_pkg;
    typedef enum logic {IDLE, PKT} pkt_state_e;
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo: power-of-two synchronous FIFO with combinational head and registered count
module noc_flit_fifo import noc_pkg::*; #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [W-1:0]              din_i,
    output logic [W-1:0]              dout_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          wr;
    // a full FIFO still accepts when the head leaves in the same cycle
    assign wr      = push_i && (!full_o || pop_i);
    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = count_q == '0;
    assign full_o  = count_q == CW'(DEPTH);
    assign count_o = count_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(wr) - CW'(pop_i);
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/noc_credit_relay.sv
// noc_credit_relay: buffered credit-flow link stage forwarding flits only while downstream credits remain
module noc_credit_relay import noc_pkg::*; #(
    parameter int FLIT_WIDTH         = 32,
    parameter int DEST_WIDTH         = 6,
    parameter int BUFFER_DEPTH       = 4,
    parameter int DOWNSTREAM_CREDITS = 8
) (
    input  logic                                   clk_noc,
    input  logic                                   rst_noc_sync,
    input  logic [FLIT_WIDTH-1:0]                  data_in,
    input  logic [DEST_WIDTH-1:0]                  dest_in,
    input  logic                                   is_tail_in,
    input  logic                                   send_in,
    output logic                                   credit_out,
    output logic [FLIT_WIDTH-1:0]                  data_out,
    output logic [DEST_WIDTH-1:0]                  dest_out,
    output logic                                   is_tail_out,
    output logic                                   send_out,
    input  logic                                   credit_in,
    output logic [cnt_w(BUFFER_DEPTH)-1:0]         occupancy,
    output logic [cnt_w(DOWNSTREAM_CREDITS)-1:0]   credits_avail,
    output logic                                   in_packet,
    output logic                                   overflow_err,
    output logic                                   credit_err
);
    localparam int CW = cnt_w(DOWNSTREAM_CREDITS);
    localparam logic [CW-1:0] MAX_CRED = CW'(DOWNSTREAM_CREDITS);
    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  tail;
    } flit_t;
    flit_t         in_flit, head;
    logic          empty, full, pop, at_max;
    logic [CW-1:0] credits_q, credits_d;
    pkt_state_e    state_q;
    assign in_flit       = '{data: data_in, dest: dest_in, tail: is_tail_in};
    assign pop           = !empty && credits_q != '0;
    assign at_max        = credits_q == MAX_CRED;
    assign credits_avail = credits_q;
    assign in_packet     = state_q == PKT;
    // a returned credit and a spent credit in the same cycle cancel out
    always_comb credits_d = (credit_in && !pop) ? (at_max ? credits_q : credits_q + 1'b1)
                          : (pop && !credit_in) ? credits_q - 1'b1 : credits_q;
    noc_flit_fifo #(.W($bits(flit_t)), .DEPTH(BUFFER_DEPTH)) u_fifo (
        .clk     (clk_noc),
        .rst     (rst_noc_sync),
        .push_i  (send_in),
        .pop_i   (pop),
        .din_i   (in_flit),
        .dout_o  (head),
        .empty_o (empty),
        .full_o  (full),
        .count_o (occupancy)
    );
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            send_out     <= 1'b0;
            credit_out   <= 1'b0;
            data_out     <= '0;
            dest_out     <= '0;
            is_tail_out  <= 1'b0;
            credits_q    <= MAX_CRED;
            state_q      <= IDLE;
            overflow_err <= 1'b0;
            credit_err   <= 1'b0;
        end else begin
            send_out     <= pop;
            credit_out   <= pop;
            credits_q    <= credits_d;
            overflow_err <= overflow_err | (send_in & full & !pop);
            credit_err   <= credit_err | (credit_in & !pop & at_max);
            if (pop) begin
                data_out    <= head.data;
                dest_out    <= head.dest;
                is_tail_out <= head.tail;
                state_q     <= head.tail ? IDLE : PKT;
            end
        end
    end
endmodule

// File: tb/tb_noc_credit_relay.sv
// tb_noc_credit_relay: directed vector table plus starvation and reset sequences for noc_credit_relay
module tb_noc_credit_relay;
    logic        clk_noc = 1'b0;
    logic        rst_noc_sync = 1'b1;
    logic [31:0] data_in = '0;
    logic [5:0]  dest_in = '0;
    logic        is_tail_in = 1'b0;
    logic        send_in = 1'b0;
    logic        credit_in = 1'b0;
    logic        credit_out, is_tail_out, send_out, in_packet, overflow_err, credit_err;
    logic [31:0] data_out;
    logic [5:0]  dest_out;
    logic [2:0]  occupancy;
    logic [3:0]  credits_avail;
    int          pass_cnt = 0;
    int          total = 0;

    noc_credit_relay dut (
        .clk_noc       (clk_noc),
        .rst_noc_sync  (rst_noc_sync),
        .data_in       (data_in),
        .dest_in       (dest_in),
        .is_tail_in    (is_tail_in),
        .send_in       (send_in),
        .credit_out    (credit_out),
        .data_out      (data_out),
        .dest_out      (dest_out),
        .is_tail_out   (is_tail_out),
        .send_out      (send_out),
        .credit_in     (credit_in),
        .occupancy     (occupancy),
        .credits_avail (credits_avail),
        .in_packet     (in_packet),
        .overflow_err  (overflow_err),
        .credit_err    (credit_err)
    );

    always #5 clk_noc = ~clk_noc;

    typedef struct packed {
        logic        snd;
        logic        cin;
        logic [31:0] d;
        logic [5:0]  ds;
        logic        tl;
        logic        e_snd;
        logic        e_cr;
        logic [31:0] e_d;
        logic [5:0]  e_ds;
        logic        e_tl;
        logic [2:0]  e_occ;
        logic [3:0]  e_cred;
        logic        e_pkt;
        logic        e_ovf;
        logic        e_cerr;
    } vec_t;
    vec_t tv [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    initial begin
        int pulses;
        int quiet;
        tv[0]  = '{1'b1, 1'b0, 32'hDEADBEEF, 6'h05, 1'b1, 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 3'd1, 4'd8, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 6'h05, 1'b1, 3'd0, 4'd7, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 6'h05, 1'b1, 3'd0, 4'd7, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 1'b0, 32'h11111111, 6'h01, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 6'h05, 1'b1, 3'd1, 4'd7, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{1'b1, 1'b1, 32'h22222222, 6'h02, 1'b0, 1'b1, 1'b1, 32'h11111111, 6'h01, 1'b0, 3'd1, 4'd7, 1'b1, 1'b0, 1'b0};
        tv[5]  = '{1'b1, 1'b1, 32'h33333333, 6'h03, 1'b0, 1'b1, 1'b1, 32'h22222222, 6'h02, 1'b0, 3'd1, 4'd7, 1'b1, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 1'b1, 32'h44444444, 6'h04, 1'b1, 1'b1, 1'b1, 32'h33333333, 6'h03, 1'b0, 3'd1, 4'd7, 1'b1, 1'b0, 1'b0};
        tv[7]  = '{1'b0, 1'b1, 32'h0, 6'h00, 1'b0, 1'b1, 1'b1, 32'h44444444, 6'h04, 1'b1, 3'd0, 4'd7, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 1'b0, 1'b0, 32'h44444444, 6'h04, 1'b1, 3'd0, 4'd7, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 32'h0, 6'h00, 1'b0, 1'b0, 1'b0, 32'h44444444, 6'h04, 1'b1, 3'd0, 4'd8, 1'b0, 1'b0, 1'b0};
        tv[10] = '{1'b0, 1'b1, 32'h0, 6'h00, 1'b0, 1'b0, 1'b0, 32'h44444444, 6'h04, 1'b1, 3'd0, 4'd8, 1'b0, 1'b0, 1'b1};
        tv[11] = '{1'b1, 1'b0, 32'h55555555, 6'h06, 1'b1, 1'b0, 1'b0, 32'h44444444, 6'h04, 1'b1, 3'd1, 4'd8, 1'b0, 1'b0, 1'b1};
        tv[12] = '{1'b0, 1'b1, 32'h0, 6'h00, 1'b0, 1'b1, 1'b1, 32'h55555555, 6'h06, 1'b1, 3'd0, 4'd8, 1'b0, 1'b0, 1'b1};
        tv[13] = '{1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 1'b0, 1'b0, 32'h55555555, 6'h06, 1'b1, 3'd0, 4'd8, 1'b0, 1'b0, 1'b1};

        repeat (3) tick();
        rst_noc_sync = 1'b0;
        chk("reset send_out", 64'(send_out), 64'd0);
        chk("reset credit_out", 64'(credit_out), 64'd0);
        chk("reset data_out", 64'(data_out), 64'd0);
        chk("reset dest_out", 64'(dest_out), 64'd0);
        chk("reset is_tail_out", 64'(is_tail_out), 64'd0);
        chk("reset occupancy", 64'(occupancy), 64'd0);
        chk("reset credits_avail", 64'(credits_avail), 64'd8);
        chk("reset in_packet", 64'(in_packet), 64'd0);
        chk("reset overflow_err", 64'(overflow_err), 64'd0);
        chk("reset credit_err", 64'(credit_err), 64'd0);

        for (int i = 0; i < 14; i++) begin
            send_in    = tv[i].snd;
            credit_in  = tv[i].cin;
            data_in    = tv[i].d;
            dest_in    = tv[i].ds;
            is_tail_in = tv[i].tl;
            tick();
            chk($sformatf("v%0d send_out", i), 64'(send_out), 64'(tv[i].e_snd));
            chk($sformatf("v%0d credit_out", i), 64'(credit_out), 64'(tv[i].e_cr));
            chk($sformatf("v%0d data_out", i), 64'(data_out), 64'(tv[i].e_d));
            chk($sformatf("v%0d dest_out", i), 64'(dest_out), 64'(tv[i].e_ds));
            chk($sformatf("v%0d is_tail_out", i), 64'(is_tail_out), 64'(tv[i].e_tl));
            chk($sformatf("v%0d occupancy", i), 64'(occupancy), 64'(tv[i].e_occ));
            chk($sformatf("v%0d credits_avail", i), 64'(credits_avail), 64'(tv[i].e_cred));
            chk($sformatf("v%0d in_packet", i), 64'(in_packet), 64'(tv[i].e_pkt));
            chk($sformatf("v%0d overflow_err", i), 64'(overflow_err), 64'(tv[i].e_ovf));
            chk($sformatf("v%0d credit_err", i), 64'(credit_err), 64'(tv[i].e_cerr));
        end
        send_in = 1'b0;
        credit_in = 1'b0;

        rst_noc_sync = 1'b1;
        tick();
        rst_noc_sync = 1'b0;
        chk("rst clears credit_err", 64'(credit_err), 64'd0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            send_in = 1'b1;
            data_in = 32'(k + 1);
            dest_in = 6'(k);
            is_tail_in = 1'b1;
            tick();
            if (send_out) begin
                chk($sformatf("starve order %0d", pulses), 64'(data_out), 64'(pulses + 1));
                pulses++;
            end
        end
        send_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (send_out) pulses++;
        end
        chk("starve pulse count", 64'(pulses), 64'd8);
        chk("starve occupancy", 64'(occupancy), 64'd4);
        chk("starve credits", 64'(credits_avail), 64'd0);
        chk("starve no overflow yet", 64'(overflow_err), 64'd0);
        send_in = 1'b1;
        data_in = 32'd100;
        tick();
        send_in = 1'b0;
        chk("overflow_err set", 64'(overflow_err), 64'd1);
        chk("overflow occupancy held", 64'(occupancy), 64'd4);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("credit edge send_out", 64'(send_out), 64'd0);
        chk("credit edge credits", 64'(credits_avail), 64'd1);
        tick();
        chk("release send_out", 64'(send_out), 64'd1);
        chk("release credit_out", 64'(credit_out), 64'd1);
        chk("release data", 64'(data_out), 64'd9);
        chk("release credits", 64'(credits_avail), 64'd0);
        chk("release occupancy", 64'(occupancy), 64'd3);
        tick();
        chk("release single send_out", 64'(send_out), 64'd0);

        rst_noc_sync = 1'b1;
        tick();
        rst_noc_sync = 1'b0;
        chk("midrst occupancy", 64'(occupancy), 64'd0);
        chk("midrst credits", 64'(credits_avail), 64'd8);
        chk("midrst overflow_err", 64'(overflow_err), 64'd0);
        quiet = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (send_out || credit_out) quiet++;
        end
        chk("midrst no pulses", 64'(quiet), 64'd0);
        chk("midrst occupancy stays", 64'(occupancy), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
